// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a 4-bit loadable up-counter.
// The counter has no enable, so this block owns its load path. It holds
// the count by reloading the current value, presets a start value, and runs
// up to a terminal value. At the terminal value it either stops (one-shot)
// or reloads the start value (periodic). It also reports terminal ticks,
// one-shot completion, and a saturating count of completed periods.
module counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_periodic,
    input  logic [WIDTH-1:0]  start_val,
    input  logic [WIDTH-1:0]  end_val,
    input  logic [WIDTH-1:0]  ctr_count,
    output logic              ctr_load,
    output logic [WIDTH-1:0]  ctr_load_data,
    output logic              busy,
    output logic              tick,
    output logic              done,
    output logic [PCNT_W-1:0] period_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_start;
    logic [WIDTH-1:0]   r_end;
    logic               r_mode;
    logic               r_busy;
    logic               r_done;
    logic [PCNT_W-1:0]  r_pcnt;

    logic               w_at_end;
    logic               w_run_tick;

    assign w_at_end   = (ctr_count == r_end);
    // A stop in RUN masks the terminal event entirely (no tick, no period).
    assign w_run_tick = (r_state == S_RUN) && !stop && w_at_end;

    // tick follows the counter value in the same cycle, so it is decoded
    // here rather than registered; busy and done come from registers.
    assign tick       = w_run_tick;
    assign busy       = r_busy;
    assign done       = r_done;
    assign period_cnt = r_pcnt;

    // Counter load path: the counter registers these, so they are combinational.
    // The default reloads ctr_count, which makes the counter hold.
    always_comb begin
        ctr_load      = 1'b1;
        ctr_load_data = ctr_count;
        case (r_state)
            S_ARM: begin
                if (!stop) begin
                    ctr_load_data = r_start;
                end
            end
            S_RUN: begin
                if (!stop) begin
                    if (w_at_end) begin
                        if (r_mode) begin
                            ctr_load_data = r_start;
                        end
                    end else begin
                        ctr_load = 1'b0;
                    end
                end
            end
            default: begin
                ctr_load      = 1'b1;
                ctr_load_data = ctr_count;
            end
        endcase
    end

    // Sequencing FSM with latched run parameters and registered busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_start <= '0;
            r_end   <= '0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pcnt  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_start <= start_val;
                        r_end   <= end_val;
                        r_mode  <= mode_periodic;
                        r_pcnt  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_at_end) begin
                        if (r_pcnt != {PCNT_W{1'b1}}) begin
                            r_pcnt <= r_pcnt + {{(PCNT_W-1){1'b0}}, 1'b1};
                        end
                        if (!r_mode) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: closes the loop through a behavioural 4-bit
// loadable counter. Each driven cycle pushes its expected outputs to a
// scoreboard queue. A negedge monitor pops one entry per cycle and compares it.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_periodic = 1'b0;
    logic [3:0] start_val = 4'd0;
    logic [3:0] end_val = 4'd0;
    logic [3:0] ctr_count;
    logic       ctr_load;
    logic [3:0] ctr_load_data;
    logic       busy;
    logic       tick;
    logic       done;
    logic [7:0] period_cnt;

    // Controlled counter: increments every clock unless load is high.
    logic [3:0] cnt_q = 4'd0;
    assign ctr_count = cnt_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ctr_load) cnt_q <= ctr_load_data;
        else          cnt_q <= cnt_q + 4'd1;
    end

    counter_seq_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .mode_periodic (mode_periodic),
        .start_val     (start_val),
        .end_val       (end_val),
        .ctr_count     (ctr_count),
        .ctr_load      (ctr_load),
        .ctr_load_data (ctr_load_data),
        .busy          (busy),
        .tick          (tick),
        .done          (done),
        .period_cnt    (period_cnt)
    );

    typedef struct {
        string tag;
        int    cnt;
        int    load;
        int    tck;
        int    dn;
        int    bsy;
        int    pcnt;
    } exp_t;

    exp_t  sb_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    n_txn    = 0;
    string cur_tag  = "init";

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_assert++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_txn++;
            check_eq({e.tag, ".count"},  int'(ctr_count),  e.cnt);
            check_eq({e.tag, ".load"},   int'(ctr_load),   e.load);
            check_eq({e.tag, ".tick"},   int'(tick),       e.tck);
            check_eq({e.tag, ".done"},   int'(done),       e.dn);
            check_eq({e.tag, ".busy"},   int'(busy),       e.bsy);
            check_eq({e.tag, ".pcnt"},   int'(period_cnt), e.pcnt);
            $display("txn %0d %s: count=%0d load=%0b tick=%0b done=%0b busy=%0b pcnt=%0d",
                     n_txn, e.tag, ctr_count, ctr_load, tick, done, busy, period_cnt);
        end
    end

    // Drive one cycle of control inputs and record what that cycle must show.
    task automatic drive_push(input logic s, input logic p, input int e_cnt, input int e_load,
                              input int e_tick, input int e_done, input int e_busy,
                              input int e_pcnt);
        exp_t e;
        start = s;
        stop  = p;
        e.tag = cur_tag; e.cnt = e_cnt; e.load = e_load; e.tck = e_tick;
        e.dn = e_done; e.bsy = e_busy; e.pcnt = e_pcnt;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic s, input logic p, input int e_cnt, input int e_load,
                       input int e_tick, input int e_done, input int e_busy, input int e_pcnt);
        drive_push(s, p, e_cnt, e_load, e_tick, e_done, e_busy, e_pcnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b1;
        #1;
        check_eq("rst.busy", int'(busy), 0);
        check_eq("rst.tick", int'(tick), 0);
        check_eq("rst.done", int'(done), 0);
        check_eq("rst.pcnt", int'(period_cnt), 0);
        check_eq("rst.load", int'(ctr_load), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: one-shot 3 -> 5, plus start ignored in DONE
        cur_tag = "oneshot";
        mode_periodic = 1'b0; start_val = 4'd3; end_val = 4'd5;
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 3, 0, 0, 0, 1, 0);
        cyc(0, 0, 4, 0, 0, 0, 1, 0);
        cyc(0, 0, 5, 1, 1, 0, 1, 0);
        cyc(1, 0, 5, 1, 0, 1, 0, 1);
        cyc(0, 0, 5, 1, 0, 0, 0, 1);
        cyc(0, 0, 5, 1, 0, 0, 0, 1);

        // 2: periodic 2 -> 4, inputs changed after latching, then stop
        cur_tag = "periodic";
        mode_periodic = 1'b1; start_val = 4'd2; end_val = 4'd4;
        cyc(1, 0, 5, 1, 0, 0, 0, 1);
        start_val = 4'd9; end_val = 4'd12; mode_periodic = 1'b0;
        cyc(0, 0, 5, 1, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 2 + (i % 3), (i % 3 == 2) ? 1 : 0, (i % 3 == 2) ? 1 : 0, 0, 1, i / 3);
        end
        cyc(0, 1, 2, 1, 0, 0, 1, 3);
        cyc(0, 0, 2, 1, 0, 0, 0, 3);

        // 3: wrap-around one-shot 14 -> 1
        cur_tag = "wrap";
        mode_periodic = 1'b0; start_val = 4'd14; end_val = 4'd1;
        cyc(1, 0, 2, 1, 0, 0, 0, 3);
        cyc(0, 0, 2, 1, 0, 0, 1, 0);
        cyc(0, 0, 14, 0, 0, 0, 1, 0);
        cyc(0, 0, 15, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 1, 0, 1);
        cyc(0, 0, 1, 1, 0, 0, 0, 1);

        // 4: stop at count 4 during a 3 -> 9 run
        cur_tag = "stop_mid";
        start_val = 4'd3; end_val = 4'd9;
        cyc(1, 0, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 0, 1, 0);
        cyc(0, 0, 3, 0, 0, 0, 1, 0);
        cyc(0, 1, 4, 1, 0, 0, 1, 0);
        cyc(0, 0, 4, 1, 0, 0, 0, 0);

        // 5: start+stop together in IDLE, then a restart with start pulsed in RUN
        cur_tag = "start_stop";
        cyc(1, 1, 4, 1, 0, 0, 0, 0);
        cyc(0, 0, 4, 1, 0, 0, 0, 0);
        cur_tag = "restart";
        cyc(1, 0, 4, 1, 0, 0, 0, 0);
        cyc(0, 0, 4, 1, 0, 0, 1, 0);
        cyc(0, 0, 3, 0, 0, 0, 1, 0);
        start_val = 4'd0; mode_periodic = 1'b1;
        cyc(1, 0, 4, 0, 0, 0, 1, 0);
        for (int c = 5; c <= 8; c++) cyc(0, 0, c, 0, 0, 0, 1, 0);
        cur_tag = "stop_term";
        cyc(0, 1, 9, 1, 0, 0, 1, 0);
        cyc(0, 0, 9, 1, 0, 0, 0, 0);

        // 6: async reset mid-run at count 6 (which is also the terminal value)
        cur_tag = "async_rst";
        mode_periodic = 1'b1; start_val = 4'd4; end_val = 4'd6;
        cyc(1, 0, 9, 1, 0, 0, 0, 0);
        cyc(0, 0, 9, 1, 0, 0, 1, 0);
        cyc(0, 0, 4, 0, 0, 0, 1, 0);
        cyc(0, 0, 5, 0, 0, 0, 1, 0);
        cyc(0, 0, 6, 1, 1, 0, 1, 0);
        cyc(0, 0, 4, 0, 0, 0, 1, 1);
        cyc(0, 0, 5, 0, 0, 0, 1, 1);
        drive_push(0, 0, 6, 1, 1, 0, 1, 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("arst.busy", int'(busy), 0);
        check_eq("arst.tick", int'(tick), 0);
        check_eq("arst.done", int'(done), 0);
        check_eq("arst.pcnt", int'(period_cnt), 0);
        check_eq("arst.load", int'(ctr_load), 1);
        check_eq("arst.ldata", int'(ctr_load_data), 6);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 6, 1, 0, 0, 0, 0);

        // 7: start == end periodic, tick every RUN cycle, period count saturates
        cur_tag = "saturate";
        mode_periodic = 1'b1; start_val = 4'd7; end_val = 4'd7;
        cyc(1, 0, 6, 1, 0, 0, 0, 0);
        cyc(0, 0, 6, 1, 0, 0, 1, 0);
        for (int i = 0; i < 260; i++) begin
            cyc(0, 0, 7, 1, 1, 0, 1, (i > 255) ? 255 : i);
        end
        cyc(0, 1, 7, 1, 0, 0, 1, 255);
        cyc(0, 0, 7, 1, 0, 0, 0, 255);

        @(negedge clk);
        #1;
        check_eq("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
